// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared definitions for the debounced edge-capture PIO.
//               Register address map and the Avalon-MM data bus width.
// Revision    : 1.0  initial release
// ============================================================================
package pio_pkg;

    // Avalon-MM data bus width
    localparam int c_BUS_W = 32;

    // Register map (3-bit word address)
    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RISE  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_CAP   = 3'd3;
    localparam logic [2:0] ADDR_FALL  = 3'd4;
    localparam logic [2:0] ADDR_DBLIM = 3'd5;

endpackage : pio_pkg
`default_nettype wire

// File: rtl/pio_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : pio_debounce_ch
// Description : One input channel: SYNC_STAGES-flop synchroniser followed by
//               a saturating tick counter that accepts a new level only after
//               it has disagreed with the current stable level for 'limit'
//               consecutive prescaler ticks. limit == 0 bypasses the filter.
// Ports       : clk, reset_n (async, active-low)
//               in_raw  - raw asynchronous input bit
//               tick    - one-cycle debounce tick from the shared prescaler
//               limit   - debounce limit in ticks
//               stable  - debounced level
// Revision    : 1.0  initial release
// ============================================================================
module pio_debounce_ch
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_raw,
    input  logic                tick,
    input  logic [DB_CNT_W-1:0] limit,
    output logic                stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_CNT_W-1:0]    r_cnt;
    logic                   r_stable;
    logic                   w_sync;
    logic [DB_CNT_W:0]      w_cnt_inc;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    // One extra bit so the compare against limit cannot wrap at all-ones.
    assign w_cnt_inc = {1'b0, r_cnt} + {{DB_CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_raw};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (limit == '0) begin
            r_cnt    <= '0;
            r_stable <= w_sync;
        end else if (w_sync == r_stable) begin
            r_cnt    <= '0;
        end else if (tick) begin
            if (w_cnt_inc >= {1'b0, limit}) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else if (r_cnt != '1) begin
                r_cnt    <= w_cnt_inc[DB_CNT_W-1:0];
            end
        end
    end

    assign stable = r_stable;

endmodule : pio_debounce_ch
`default_nettype wire

// File: rtl/pio_debounced_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_debounced_edge_irq
// Description : Avalon-MM PIO with per-channel debounce, software-selectable
//               rising/falling edge capture and a maskable level interrupt.
//               Optional macro PIO_BIT_CLEAR_EN: EDGE_CAP becomes
//               write-1-to-clear (set wins over clear); when undefined any
//               EDGE_CAP write clears all bits (clear wins).
// Ports       : clk, reset_n (async, active-low)
//               address[2:0], chipselect, write_n, writedata[31:0] - slave
//               in_port[WIDTH-1:0] - raw asynchronous inputs
//               irq                - level interrupt
//               readdata[31:0]     - registered read data, 1-cycle latency
// Revision    : 1.0  initial release
// ============================================================================
module pio_debounced_edge_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 1000,
    parameter int DB_CNT_W    = 8,
    parameter int DB_RESET    = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [c_BUS_W-1:0] writedata,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq,
    output logic [c_BUS_W-1:0] readdata
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    r_pre;
    logic                w_tick;
    logic [WIDTH-1:0]    w_stable;
    logic [WIDTH-1:0]    r_stable_d;
    logic [WIDTH-1:0]    r_rise_en;
    logic [WIDTH-1:0]    r_fall_en;
    logic [WIDTH-1:0]    r_irq_mask;
    logic [WIDTH-1:0]    r_edge_cap;
    logic [DB_CNT_W-1:0] r_db_limit;
    logic [WIDTH-1:0]    w_edge;
    logic                w_wr;
    logic [WIDTH-1:0]    w_wr_bits;
    logic [c_BUS_W-1:0]  w_rdata;
    logic [c_BUS_W-1:0]  r_rdata;
    logic                w_unused_wdata;

    assign w_wr           = chipselect && !write_n;
    assign w_wr_bits      = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    // Shared debounce prescaler
    assign w_tick = (r_pre == c_PRE_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            pio_debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CNT_W    (DB_CNT_W)
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .in_raw  (in_port[i]),
                .tick    (w_tick),
                .limit   (r_db_limit),
                .stable  (w_stable[i])
            );
        end
    endgenerate

    // Edge detection on the debounced level
    assign w_edge = (w_stable & ~r_stable_d & r_rise_en)
                  | (~w_stable & r_stable_d & r_fall_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_irq_mask <= '0;
            r_db_limit <= DB_CNT_W'(DB_RESET);
        end else begin
            r_stable_d <= w_stable;
            if (w_wr) begin
                case (address)
                    ADDR_RISE:  r_rise_en  <= w_wr_bits;
                    ADDR_MASK:  r_irq_mask <= w_wr_bits;
                    ADDR_FALL:  r_fall_en  <= w_wr_bits;
                    ADDR_DBLIM: r_db_limit <= writedata[DB_CNT_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    // Edge capture register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
`ifdef PIO_BIT_CLEAR_EN
            // Write-1-to-clear; a same-cycle edge re-sets the bit.
            if (w_wr && (address == ADDR_CAP)) begin
                r_edge_cap <= (r_edge_cap & ~w_wr_bits) | w_edge;
            end else begin
                r_edge_cap <= r_edge_cap | w_edge;
            end
`else
            // Legacy behaviour: any write clears everything, dropping a
            // same-cycle edge.
            if (w_wr && (address == ADDR_CAP)) begin
                r_edge_cap <= '0;
            end else begin
                r_edge_cap <= r_edge_cap | w_edge;
            end
`endif
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

    // Read mux, registered every cycle
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:  w_rdata[WIDTH-1:0]    = w_stable;
            ADDR_RISE:  w_rdata[WIDTH-1:0]    = r_rise_en;
            ADDR_MASK:  w_rdata[WIDTH-1:0]    = r_irq_mask;
            ADDR_CAP:   w_rdata[WIDTH-1:0]    = r_edge_cap;
            ADDR_FALL:  w_rdata[WIDTH-1:0]    = r_fall_en;
            ADDR_DBLIM: w_rdata[DB_CNT_W-1:0] = r_db_limit;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign readdata = r_rdata;

endmodule : pio_debounced_edge_irq
`default_nettype wire

// File: tb/tb_pio_debounced_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_debounced_edge_irq
// Description : Self-checking bench for pio_debounced_edge_irq (WIDTH=4,
//               SYNC_STAGES=2, PRESCALE=4). Register vectors from a table,
//               directed corner-case sequences, then randomized traffic
//               compared cycle by cycle against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pio_debounced_edge_irq;

    localparam int c_W     = 4;
    localparam int c_SYNC  = 2;
    localparam int c_PRE   = 4;
    localparam int c_CNT_W = 8;
    localparam int c_DBRST = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [c_W-1:0]    in_port;
    logic              irq;
    logic [31:0]       readdata;

    int n_tests = 0;
    int n_fail  = 0;

    pio_debounced_edge_irq #(
        .WIDTH       (c_W),
        .SYNC_STAGES (c_SYNC),
        .PRESCALE    (c_PRE),
        .DB_CNT_W    (c_CNT_W),
        .DB_RESET    (c_DBRST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .irq        (irq),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    logic [c_W-1:0]     m_sync [c_SYNC];  // [0] = newest sampled input
    logic [c_W-1:0]     m_stable, m_stable_d, m_rise, m_fall, m_mask, m_cap;
    logic [c_CNT_W-1:0] m_lim;
    int                 m_cnt [c_W];
    int                 m_edges;
    logic [31:0]        m_rd;
    logic               m_irq;

    task automatic model_reset();
        for (int k = 0; k < c_SYNC; k++) m_sync[k] = '0;
        for (int i = 0; i < c_W; i++) m_cnt[i] = 0;
        m_stable = '0; m_stable_d = '0; m_rise = '0; m_fall = '0;
        m_mask = '0; m_cap = '0; m_lim = c_CNT_W'(c_DBRST);
        m_edges = 0; m_rd = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [c_W-1:0] s, edg, nst, ncap;
        logic [31:0]    rd;
        bit             tk;
        bit             we;
        if (!reset_n) begin
            model_reset();
            return;
        end
        s  = m_sync[c_SYNC-1];
        tk = (m_edges % c_PRE) == (c_PRE - 1);
        m_edges++;
        edg = (m_stable & ~m_stable_d & m_rise) | (~m_stable & m_stable_d & m_fall);
        we  = chipselect && !write_n;
        rd  = '0;
        case (address)
            3'd0: rd[c_W-1:0]     = m_stable;
            3'd1: rd[c_W-1:0]     = m_rise;
            3'd2: rd[c_W-1:0]     = m_mask;
            3'd3: rd[c_W-1:0]     = m_cap;
            3'd4: rd[c_W-1:0]     = m_fall;
            3'd5: rd[c_CNT_W-1:0] = m_lim;
            default: rd = '0;
        endcase
        if (we && address == 3'd3) begin
`ifdef PIO_BIT_CLEAR_EN
            ncap = (m_cap & ~writedata[c_W-1:0]) | edg;
`else
            ncap = '0;
`endif
        end else begin
            ncap = m_cap | edg;
        end
        nst = m_stable;
        for (int i = 0; i < c_W; i++) begin
            if (m_lim == 0) begin
                nst[i] = s[i];
                m_cnt[i] = 0;
            end else if (s[i] == m_stable[i]) begin
                m_cnt[i] = 0;
            end else if (tk) begin
                if (m_cnt[i] + 1 >= int'(m_lim)) begin
                    nst[i] = s[i];
                    m_cnt[i] = 0;
                end else if (m_cnt[i] < (1 << c_CNT_W) - 1) begin
                    m_cnt[i]++;
                end
            end
        end
        m_stable_d = m_stable;
        m_stable   = nst;
        m_cap      = ncap;
        m_rd       = rd;
        for (int k = c_SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = in_port;
        if (we) begin
            case (address)
                3'd1: m_rise = writedata[c_W-1:0];
                3'd2: m_mask = writedata[c_W-1:0];
                3'd4: m_fall = writedata[c_W-1:0];
                3'd5: m_lim  = writedata[c_CNT_W-1:0];
                default: ;
            endcase
        end
        m_irq = |(m_cap & m_mask);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, compare after.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_readdata", readdata, m_rd);
        chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        step();
        d = readdata;
    endtask

    // Wait (bounded) until DATA bit b equals v; expiry counts as a failure.
    task automatic wait_data(input int b, input logic v, input int max_cyc, output int n);
        address = 3'd0;
        n = 0;
        do begin
            step();
            n++;
        end while (readdata[b] !== v && n < max_cyc);
        chk($sformatf("wait_data_bit%0d", b), {31'd0, readdata[b]}, {31'd0, v});
    endtask

    typedef struct {
        string       name;
        logic [2:0]  addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        int          n;

        // -------- vector table --------
        vecs.push_back('{"rst_data",  3'd0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rst_rise",  3'd1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rst_mask",  3'd2, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rst_cap",   3'd3, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rst_fall",  3'd4, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rst_dblim", 3'd5, 1'b0, 32'h0, 32'd10});
        vecs.push_back('{"rst_a6",    3'd6, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rst_a7",    3'd7, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"rw_rise",   3'd1, 1'b1, 32'hFFFF_FFFF, 32'hF});
        vecs.push_back('{"rw_mask",   3'd2, 1'b1, 32'h0000_0005, 32'h5});
        vecs.push_back('{"rw_fall",   3'd4, 1'b1, 32'h1234_567A, 32'hA});
        vecs.push_back('{"rw_dblim",  3'd5, 1'b1, 32'h0000_01FF, 32'hFF});
        vecs.push_back('{"rw_a6",     3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"rw_a7",     3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"rw_data",   3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"rw_cap",    3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"rw_rise0",  3'd1, 1'b1, 32'h0, 32'h0});
        vecs.push_back('{"rw_mask0",  3'd2, 1'b1, 32'h0, 32'h0});
        vecs.push_back('{"rw_fall0",  3'd4, 1'b1, 32'h0, 32'h0});

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        chk("reset_irq", {31'd0, irq}, 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].wr) bus_write(vecs[k].addr, vecs[k].wdata);
            bus_read(vecs[k].addr, rd);
            chk(vecs[k].name, rd, vecs[k].exp);
        end

        // -------- debounce: short pulse rejected, long level accepted --------
        bus_write(3'd5, 32'd3);
        in_port = 4'h1;
        repeat (8) step();
        in_port = 4'h0;
        repeat (20) step();
        bus_read(3'd0, rd);
        chk("pulse_data", rd, 32'h0);
        bus_read(3'd3, rd);
        chk("pulse_cap", rd, 32'h0);
        in_port = 4'h1;
        wait_data(0, 1'b1, 40, n);
        chk("debounce_latency_in_range", {31'd0, (n >= 11 && n <= 19)}, 32'd1);
        repeat (5) step();
        in_port = 4'h0;
        wait_data(0, 1'b0, 40, n);

        // -------- edge modes --------
        bus_write(3'd1, 32'h1);
        bus_write(3'd4, 32'h2);
        bus_write(3'd2, 32'h3);
        in_port = 4'h1;
        n = 0;
        do begin step(); n++; end while (irq !== 1'b1 && n < 40);
        chk("rise0_irq", {31'd0, irq}, 32'd1);
        bus_read(3'd3, rd);
        chk("rise0_cap", rd, 32'h1);
        in_port = 4'h3;
        wait_data(1, 1'b1, 40, n);
        bus_read(3'd3, rd);
        chk("rise1_nocap", rd, 32'h1);
        in_port = 4'h1;
        wait_data(1, 1'b0, 40, n);
        bus_read(3'd3, rd);
        chk("fall1_cap", rd, 32'h3);

        // -------- software clear --------
`ifdef PIO_BIT_CLEAR_EN
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        chk("w1c_bit0", rd, 32'h2);
        chk("w1c_bit0_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd3, 32'h2);
        bus_read(3'd3, rd);
        chk("w1c_bit1", rd, 32'h0);
        chk("w1c_bit1_irq", {31'd0, irq}, 32'd0);
`else
        bus_write(3'd3, 32'h0);
        bus_read(3'd3, rd);
        chk("clear_all", rd, 32'h0);
        chk("clear_all_irq", {31'd0, irq}, 32'd0);
`endif

        // -------- clear/edge collision (bypass debounce for exact timing) --------
        bus_write(3'd5, 32'd0);
        in_port = 4'h0; repeat (6) step();
        in_port = 4'h2; repeat (6) step();
        in_port = 4'h0; repeat (6) step();
        bus_read(3'd3, rd);
        chk("pre_collision_cap", rd, 32'h2);
        // Two sync flops + one stable update: the bit0 rise is pending on
        // the fourth edge, which is where the write lands.
        in_port = 4'h1;
        repeat (3) step();
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
`ifdef PIO_BIT_CLEAR_EN
        chk("collision_set_wins", rd, 32'h3);
`else
        chk("collision_clear_wins", rd, 32'h0);
`endif

        // -------- bypass latency: stable after 3 edges, readdata on the 4th --------
        in_port = 4'h0; repeat (6) step();
        in_port = 4'h4;
        address = 3'd0;
        n = 0;
        do begin step(); n++; end while (readdata[2] !== 1'b1 && n < 20);
        chk("bypass_latency", n, 32'd4);

        // -------- asynchronous reset mid-debounce --------
        in_port = 4'h5; repeat (6) step();
        chk("pre_reset_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd5, 32'd3);
        in_port = 4'hD;
        address = 3'd0;
        repeat (6) step();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        chk("async_rst_readdata", readdata, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        bus_read(3'd0, rd);
        chk("post_rst_data", rd, 32'h0);
        bus_read(3'd3, rd);
        chk("post_rst_cap", rd, 32'h0);
        bus_read(3'd5, rd);
        chk("post_rst_dblim", rd, 32'd10);

        // -------- randomized traffic against the model --------
        bus_write(3'd1, 32'hF);
        bus_write(3'd4, 32'hF);
        bus_write(3'd2, $urandom_range(1, 15));
        bus_write(3'd5, $urandom_range(0, 3));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            for (int b = 0; b < c_W; b++) begin
                if ($urandom_range(0, 24) == 0) in_port[b] = ~in_port[b];
            end
            r = $urandom_range(0, 99);
            address = 3'($urandom_range(0, 7));
            if (r < 4) begin
                chipselect = 1'b1; write_n = 1'b0;
                writedata = (address == 3'd5) ? 32'($urandom_range(0, 4)) : $urandom;
            end else if (r < 10) begin
                chipselect = 1'b1; write_n = 1'b1; writedata = $urandom;
            end else begin
                chipselect = 1'b0; write_n = 1'b1; writedata = '0;
            end
            step();
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pio_debounced_edge_irq
`default_nettype wire

// File: doc/pio_debounced_edge_irq.md
Name: pio_debounced_edge_irq

Overview:
- Parametrised successor to the team's 4-bit pushbutton PIO; Avalon-MM slave, same bus timing.
- Synchronises W input lines, debounces each line with a per-channel counter and a shared prescaler, and detects rising and/or falling edges per bit under software control.
- Edges are latched in a capture register that raises a maskable level interrupt.
- Sits between board pushbuttons/switches and the CPU interconnect.

Parameters:
- WIDTH, 4, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- PRESCALE, 1000, clk cycles per debounce tick (>=1).
- DB_CNT_W, 8, width of each per-channel debounce counter and of the limit register.
- DB_RESET, 10, reset value of the debounce limit register (ticks).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt.
- readdata  out  32  registered read data.

Interface: reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Write strobe: chipselect && !write_n. Writes take effect on the next clk edge. Reads have no side effects.
- readdata: registered, 1-cycle latency, updated every cycle from the address mux. Unused upper bits are 0. Reset value 0.
- Register map:
  - 0 DATA, RO: debounced stable[W-1:0].
  - 1 RISE_EN, RW: per-bit rising-edge enable.
  - 2 IRQ_MASK, RW.
  - 3 EDGE_CAP, RW clear (see Optional Feature).
  - 4 FALL_EN, RW.
  - 5 DB_LIMIT, RW [DB_CNT_W-1:0].
  - 6 and 7 read 0; writes to them are ignored.
- Reset values: RISE_EN, FALL_EN, IRQ_MASK, EDGE_CAP, sync chain, stable, stable_d all 0. DB_LIMIT = DB_RESET. Prescaler 0. All counters 0.
- Synchroniser: SYNC_STAGES-flop chain per bit; its output is sync[i].
- Prescaler: counts 0..PRESCALE-1. tick is high for one cycle when the count equals PRESCALE-1, then the count wraps to 0.
- Debounce, per channel i:
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Else, on tick: if cnt[i] + 1 >= DB_LIMIT, then stable[i] <= sync[i] and cnt[i] <= 0; otherwise cnt[i]++.
  - Counter saturates and never wraps.
  - DB_LIMIT == 0 is bypass: stable[i] <= sync[i] every cycle.
  - Total latency from in_port change to DATA change: SYNC_STAGES + (DB_LIMIT ticks, +/-1 tick phase) + 1 cycle.
- A DB_LIMIT write takes effect on the next comparison. In-flight counters are not cleared.
- Edge detect:
  - stable_d <= stable every cycle.
  - rise = stable & ~stable_d & RISE_EN.
  - fall = ~stable & stable_d & FALL_EN.
  - edge = rise | fall.
- EDGE_CAP[i] is set when edge[i] is 1. Bits stay set until cleared by software.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers. Reset value 0.
- Coming out of reset with an input held high: DATA rises after debounce. The edge is not captured, because RISE_EN resets to 0.
- Reset asserted mid-debounce: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro PIO_BIT_CLEAR_EN.
- Defined: a write to EDGE_CAP clears only the bits where writedata[i] == 1 (write-1-to-clear). If a bit is cleared and a new edge occurs on it in the same cycle, set wins and the bit stays 1.
- Undefined (legacy-compatible): any write to EDGE_CAP clears all bits. Clear wins over a same-cycle edge.

Decomposition:
- Shared package pio_pkg:
  - Register address localparams ADDR_DATA=0, ADDR_RISE=1, ADDR_MASK=2, ADDR_CAP=3, ADDR_FALL=4, ADDR_DBLIM=5.
  - Bus width constant 32.
- One sub-module, pio_debounce_ch: synchroniser, debounce counter and stable bit for a single channel. Instantiated WIDTH times via generate. Tick and limit come from the parent.
- Prescaler, registers, edge logic and read mux stay in the top level.

Test Plan:
- Reset values: after reset, read each address 0..7. Expect 0 everywhere except address 5 = 10. irq = 0.
- Debounce: PRESCALE=4, DB_LIMIT=3. Pulse in_port[0] high for 8 cycles, then low. DATA bit0 stays 0 and EDGE_CAP stays 0. Then hold high 20 cycles: DATA bit0 = 1 within 2 + 12 +/- 4 + 1 cycles.
- Edge modes: RISE_EN=0x1, FALL_EN=0x2, IRQ_MASK=0x3. Debounced 0->1 on bit0 sets EDGE_CAP=0x1 and irq=1. 0->1 on bit1 gives no capture; 1->0 on bit1 sets bit1.
- Clear, with PIO_BIT_CLEAR_EN: EDGE_CAP=0x3, write 0x1 to address 3. Read gives 0x2, irq stays 1. Write 0x2: read 0, irq=0.
- Clear collision, both macro settings: write EDGE_CAP in the same cycle a bit0 edge fires. With the macro, bit0 = 1. Without it, all bits = 0.
- Bypass and mid-op reset: DB_LIMIT=0, so DATA follows in_port after SYNC_STAGES+1 cycles. Assert reset_n low mid-debounce: DATA, EDGE_CAP and irq go to 0 immediately.
